mem_wait_bridge: RTL and testbench

- Parametrised successor to the current external memory model: word-organised RAM with byte/half/word access modes behind a valid/ready request and response handshake.
- Adds programmable wait states, sign or zero extension on narrow loads, and fault reporting for misaligned, reserved-mode and out-of-range accesses.
- Sits between the multicycle MIPS core's memory port and storage. It replaces the fixed single-cycle memory path with a stallable one.

---
 rtl/mem_wait_bridge.sv | 169 ++++++++++++++++
 tb/tb_mem_wait_bridge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_bridge.sv
// Word-organised RAM behind a valid/ready request/response handshake.
// Programmable wait states, narrow-load extension and access fault reporting.
module mem_wait_bridge #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_mode,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LA_W  = IDX_W + 2;
    localparam int CNT_W = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [1:0] M_WORD = 2'b00;
    localparam logic [1:0] M_HALF = 2'b01;
    localparam logic [1:0] M_BYTE = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              valid_n, fault_n;
    logic [31:0]       rdata_n;
    logic              accept, fault, commit;

    logic              l_write, l_signed;
    logic [1:0]        l_mode;
    logic [LA_W-1:0]   l_addr;
    logic [31:0]       l_wdata;

    logic              cur_write, cur_signed;
    logic [1:0]        cur_mode;
    logic [LA_W-1:0]   cur_addr;
    logic [31:0]       cur_wdata;
    logic [IDX_W-1:0]  widx;
    logic [31:0]       old_word, new_word, load_val;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;

    logic [31:0]       mem [DEPTH];

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    assign fault = (req_mode == 2'b11)
                || (req_mode == M_HALF && req_addr[0])
                || (req_mode == M_WORD && req_addr[1:0] != 2'b00)
                || (32'(req_addr[ADDR_W-1:2]) >= 32'(DEPTH));

    // With zero wait states the commit edge is the accept edge, so the
    // live request must be used instead of the latched copy.
    assign cur_write  = (state == IDLE) ? req_write  : l_write;
    assign cur_signed = (state == IDLE) ? req_signed : l_signed;
    assign cur_mode   = (state == IDLE) ? req_mode   : l_mode;
    assign cur_addr   = (state == IDLE) ? req_addr[LA_W-1:0] : l_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : l_wdata;

    assign widx      = cur_addr[LA_W-1:2];
    assign old_word  = mem[widx];
    assign lane_byte = old_word[{cur_addr[1:0], 3'b000} +: 8];
    assign lane_half = old_word[{cur_addr[1], 4'b0000} +: 16];

    always_comb begin
        new_word = old_word;
        load_val = old_word;
        unique case (cur_mode)
            M_BYTE: begin
                new_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
                load_val = {{24{cur_signed & lane_byte[7]}}, lane_byte};
            end
            M_HALF: begin
                new_word[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
                load_val = {{16{cur_signed & lane_half[15]}}, lane_half};
            end
            default: new_word = cur_wdata;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        valid_n = rsp_valid;
        rdata_n = rsp_rdata;
        fault_n = rsp_fault;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_n = RESP;
                        valid_n = 1'b1;
                        fault_n = 1'b1;
                        rdata_n = '0;
                    end else if (WAIT_CYCLES == 0) begin
                        commit = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) commit = 1'b1;
                else           cnt_n  = cnt - 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    rdata_n = '0;
                    fault_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (commit) begin
            state_n = RESP;
            valid_n = 1'b1;
            fault_n = 1'b0;
            rdata_n = cur_write ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            l_write   <= 1'b0;
            l_signed  <= 1'b0;
            l_mode    <= '0;
            l_addr    <= '0;
            l_wdata   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= valid_n;
            rsp_rdata <= rdata_n;
            rsp_fault <= fault_n;
            if (accept) begin
                l_write  <= req_write;
                l_signed <= req_signed;
                l_mode   <= req_mode;
                l_addr   <= req_addr[LA_W-1:0];
                l_wdata  <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && cur_write) mem[widx] <= new_word;
    end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench for mem_wait_bridge: vector table plus reset and
// zero-wait-state sequences.
module tb_mem_wait_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_mode = 2'b00;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        sel = 1'b0;

    logic        a_ready, a_valid, a_fault;
    logic [31:0] a_rdata;
    logic        z_ready, z_valid, z_fault;
    logic [31:0] z_rdata;
    logic        c_ready, c_valid, c_fault;
    logic [31:0] c_rdata;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_wait_bridge #(.ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(a_ready),
        .req_write(req_write), .req_mode(req_mode),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(a_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(a_rdata),
        .rsp_fault(a_fault)
    );

    mem_wait_bridge #(.ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(z_ready),
        .req_write(req_write), .req_mode(req_mode),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(z_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(z_rdata),
        .rsp_fault(z_fault)
    );

    assign c_ready = sel ? z_ready : a_ready;
    assign c_valid = sel ? z_valid : a_valid;
    assign c_fault = sel ? z_fault : a_fault;
    assign c_rdata = sel ? z_rdata : a_rdata;

    typedef struct {
        logic        wr;
        logic [1:0]  mode;
        logic        sgn;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [1:0] mode,
                                input logic sgn, input logic [15:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic fault, input int hold);
        vec_t v;
        v.wr = wr; v.mode = mode; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.fault = fault; v.hold = hold;
        vecs.push_back(v);
    endfunction

    task automatic scramble();
        req_valid  = 1'b1;
        req_write  = 1'($urandom);
        req_mode   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 16'($urandom_range(0, 15)) << 2;
        req_wdata  = $urandom;
    endtask

    task automatic txn(input vec_t v, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (v.fault || sel) ? 1 : 3;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_mode = v.mode;
        req_signed = v.sgn; req_addr = v.addr; req_wdata = v.wdata;
        rsp_ready = 1'b0;
        chk({tag, "_ready_idle"}, 32'(c_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!c_valid && lat < 20) begin
            chk({tag, "_ready_busy"}, 32'(c_ready), 32'd0);
            scramble();
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, c_rdata, v.rdata);
        chk({tag, "_fault"}, 32'(c_fault), 32'(v.fault));
        for (int i = 0; i < v.hold; i++) begin
            scramble();
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(c_valid), 32'd1);
            chk({tag, "_hold_rdata"}, c_rdata, v.rdata);
            chk({tag, "_hold_fault"}, 32'(c_fault), 32'(v.fault));
            chk({tag, "_hold_ready"}, 32'(c_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk({tag, "_exit_ready"}, 32'(c_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_clr_valid"}, 32'(c_valid), 32'd0);
        chk({tag, "_clr_rdata"}, c_rdata, 32'd0);
        chk({tag, "_clr_fault"}, 32'(c_fault), 32'd0);
        chk({tag, "_ready_back"}, 32'(c_ready), 32'd1);
    endtask

    initial begin
        add(1, 2'b00, 0, 16'h0010, 32'hDEADBEEF, 32'h0,        0, 0);
        add(0, 2'b00, 0, 16'h0010, 32'h0,        32'hDEADBEEF, 0, 0);
        add(1, 2'b10, 0, 16'h0011, 32'h000000AA, 32'h0,        0, 0);
        add(0, 2'b00, 0, 16'h0010, 32'h0,        32'hDEADAAEF, 0, 5);
        add(0, 2'b10, 1, 16'h0011, 32'h0,        32'hFFFFFFAA, 0, 0);
        add(0, 2'b10, 0, 16'h0011, 32'h0,        32'h000000AA, 0, 0);
        add(1, 2'b01, 0, 16'h0012, 32'h00008001, 32'h0,        0, 0);
        add(0, 2'b01, 1, 16'h0012, 32'h0,        32'hFFFF8001, 0, 0);
        add(0, 2'b01, 0, 16'h0012, 32'h0,        32'h00008001, 0, 0);
        add(0, 2'b00, 0, 16'h0010, 32'h0,        32'h8001AAEF, 0, 0);
        add(0, 2'b10, 0, 16'h0010, 32'h0,        32'h000000EF, 0, 0);
        add(0, 2'b10, 1, 16'h0013, 32'h0,        32'hFFFFFF80, 0, 0);
        add(0, 2'b01, 1, 16'h0010, 32'h0,        32'hFFFFAAEF, 0, 0);
        add(0, 2'b00, 0, 16'h0011, 32'h0,        32'h0,        1, 0);
        add(0, 2'b01, 0, 16'h0013, 32'h0,        32'h0,        1, 5);
        add(0, 2'b11, 0, 16'h0010, 32'h0,        32'h0,        1, 0);
        add(0, 2'b00, 0, 16'h1000, 32'h0,        32'h0,        1, 0);
        add(1, 2'b11, 0, 16'h0010, 32'hFFFFFFFF, 32'h0,        1, 0);
        add(1, 2'b00, 0, 16'h0012, 32'hFFFFFFFF, 32'h0,        1, 0);
        add(1, 2'b00, 0, 16'h1010, 32'hFFFFFFFF, 32'h0,        1, 0);
        add(0, 2'b00, 0, 16'h0010, 32'h0,        32'h8001AAEF, 0, 0);
        add(1, 2'b00, 0, 16'h0020, 32'h00000000, 32'h0,        0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_fault", 32'(a_fault), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) txn(vecs[i], $sformatf("v%0d", i));

        // Reset while the store of 0x12345678 is in its wait states.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_mode = 2'b00;
        req_addr = 16'h0020; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(a_ready), 32'd0);
        chk("midrst_valid", 32'(a_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("postrst_no_rsp", 32'(a_valid), 32'd0);
        end
        begin
            vec_t v;
            v.wr = 0; v.mode = 2'b00; v.sgn = 0; v.addr = 16'h0020;
            v.wdata = 0; v.rdata = 32'h0; v.fault = 0; v.hold = 0;
            txn(v, "postrst_load");
        end

        // Zero wait states on the second instance.
        sel = 1'b1;
        begin
            vec_t v;
            v.wr = 1; v.mode = 2'b00; v.sgn = 0; v.addr = 16'h0040;
            v.wdata = 32'h0BADF00D; v.rdata = 32'h0; v.fault = 0; v.hold = 0;
            txn(v, "w0_store");
            v.wr = 0; v.wdata = 0; v.rdata = 32'h0BADF00D;
            txn(v, "w0_load");
            v.mode = 2'b10; v.sgn = 1; v.addr = 16'h0042; v.rdata = 32'hFFFFFFAD;
            txn(v, "w0_byte");
            v.mode = 2'b00; v.addr = 16'h0041; v.rdata = 32'h0; v.fault = 1;
            txn(v, "w0_fault");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
